// File: rtl/ahb_sram_slv.sv
// ahb_sram_slv: AHB-Lite SRAM slave with a write-only mailbox byte register.
// Latency: read data in the cycle after the address phase, plus WAIT_STATES cycles.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle.
// Optional feature macro AHB_SRAM_SLV_ERR_EN: ERROR response on range/alignment/size faults.
module ahb_sram_slv #(
    parameter int          DW           = 64,
    parameter int          DEPTH        = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [2:0]    HBURST,
    input  logic [3:0]    HPROT,
    input  logic          HREADY,
    input  logic [DW-1:0] HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA,
    output logic          mbox_wr,
    output logic [7:0]    mbox_data
);

    localparam int NB      = DW / 8;
    localparam int OFFW    = $clog2(NB);
    localparam int AW      = $clog2(DEPTH);
    localparam int MB_LANE = int'(MAILBOX_ADDR[OFFW-1:0]);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t          state, state_nxt;
    logic [3:0]      wait_cnt;
    logic            dp_write, dp_mbox;
    logic [AW-1:0]   dp_idx;
    logic [NB-1:0]   dp_strb;
    logic [DW-1:0]   rd_buf;
    logic [DW-1:0]   mem [DEPTH];

    logic            acc_ok, done, wr_en, mb_done;
    logic [31:0]     rel;
    logic [AW-1:0]   ap_idx;
    logic            ap_mbox, ap_err;
    logic [OFFW-1:0] ap_mask;
    logic [NB-1:0]   ap_strb;
    logic            unused_ok;

    // Address-phase decode; ERR1 blocks acceptance so the error sequence always runs both cycles.
    assign acc_ok  = HSEL && HREADY && HTRANS[1] && (state != ST_ERR1);
    assign rel     = HADDR - BASE_ADDR;
    assign ap_idx  = rel[OFFW +: AW];
    assign ap_mbox = HWRITE && (HADDR == MAILBOX_ADDR);
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], rel};

    // Byte strobe: oversize transfers clamp to a full word, misaligned ones snap to natural alignment.
    always_comb begin
        ap_mask = '0;
        ap_strb = '0;
        for (int i = 0; i < OFFW; i++)
            if (i < int'(HSIZE)) ap_mask[i] = 1'b1;
        for (int b = 0; b < NB; b++)
            ap_strb[b] = ((OFFW'(b) & ~ap_mask) == (HADDR[OFFW-1:0] & ~ap_mask));
    end

`ifdef AHB_SRAM_SLV_ERR_EN
    localparam logic [32:0] WIN = 33'(DEPTH * NB);
    assign ap_err = (!ap_mbox && ({1'b0, rel} >= WIN)) ||
                    ((HADDR[OFFW-1:0] & ap_mask) != '0) ||
                    (HSIZE > 3'(OFFW));
`else
    assign ap_err = 1'b0;
`endif

    assign done    = (state == ST_DATA) && (wait_cnt == 4'd0);
    assign wr_en   = done && dp_write && !dp_mbox;
    assign mb_done = done && dp_write && dp_mbox;
    assign HRDATA  = (done && !dp_write) ? rd_buf : '0;

    // Next-state and bus response outputs.
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_DATA: HREADYOUT = (wait_cnt == 4'd0);
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
        if (state == ST_ERR1)
            state_nxt = ST_ERR2;
        else if (acc_ok)
            state_nxt = ap_err ? ST_ERR1 : ST_DATA;
        else if (HREADYOUT)
            state_nxt = ST_IDLE;
    end

    // State register and data-phase latches.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            dp_write <= 1'b0;
            dp_mbox  <= 1'b0;
            dp_idx   <= '0;
            dp_strb  <= '0;
        end else begin
            state <= state_nxt;
            if (acc_ok) begin
                wait_cnt <= ap_err ? 4'd0 : 4'(WAIT_STATES);
                dp_write <= HWRITE;
                dp_mbox  <= ap_mbox;
                dp_idx   <= ap_idx;
                dp_strb  <= ap_strb;
            end else if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Memory write on the completing data-phase cycle; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++)
                if (dp_strb[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    // Read capture at acceptance, merging a write to the same word completing on the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_buf <= '0;
        end else if (acc_ok && !HWRITE) begin
            for (int b = 0; b < NB; b++)
                rd_buf[8*b +: 8] <= (wr_en && (dp_idx == ap_idx) && dp_strb[b]) ?
                                    HWDATA[8*b +: 8] : mem[ap_idx][8*b +: 8];
        end
    end

    // Mailbox pulse and byte, presented the cycle after the write completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mbox_wr   <= 1'b0;
            mbox_data <= 8'd0;
        end else begin
            mbox_wr <= mb_done;
            if (mb_done) mbox_data <= HWDATA[8*MB_LANE +: 8];
        end
    end

endmodule
